// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for alu_seq.
// S_BUSY exists only when ALU_SEQ_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_SEP  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REMU = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_SEQ_MULDIV_EN
        S_BUSY = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unit: shift-add MUL, restoring DIVU/REMU, one bit per cycle.
// Present only when ALU_SEQ_MULDIV_EN is defined.
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic             mul_q;
    logic             rem_q;
    logic [WIDTH-1:0] hi_q, lo_q, opa_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   shl;
    logic             ge;

    // hi:lo is the product (MUL) or remainder:quotient (DIV/REM)
    always_comb begin
        madd = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, opa_q});
        shl  = {hi_q, lo_q[WIDTH-1]};
        ge   = (shl >= {1'b0, opa_q});
        if (mul_q) begin
            hi_d = madd[WIDTH:1];
            lo_d = {madd[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = ge ? (shl[WIDTH-1:0] - opa_q) : shl[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end
    end

    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign result  = (!mul_q && rem_q) ? hi_d : lo_d;
    assign carry   = mul_q && (hi_d != '0);
    assign divzero = !mul_q && (opa_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mul_q  <= 1'b0;
            rem_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opa_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            mul_q  <= (op == OP_MUL);
            rem_q  <= (op == OP_REMU);
            hi_q   <= '0;
            lo_q   <= (op == OP_MUL) ? b : a;
            opa_q  <= (op == OP_MUL) ? a : b;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and registered result/flags.
// Define ALU_SEQ_MULDIV_EN to add iterative MUL/DIVU/REMU.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_wordA,
    input  logic [WIDTH-1:0] i_wordB,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag_zero,
    output logic             o_flag_sign,
    output logic             o_flag_overflow,
    output logic             o_flag_carry,
    output logic             o_flag_divzero
);

    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             sign;
        logic             ovf;
        logic             carry;
        logic             divz;
    } res_t;

    state_t         state_q, state_d;
    res_t           res_q, res_d, alu_r;
    logic           load;
    logic [WIDTH:0] sum, dif;
    logic [SHW-1:0] shamt;
    logic           msb_a, msb_b;

    assign shamt = i_wordB[SHW-1:0];
    assign sum   = {1'b0, i_wordA} + {1'b0, i_wordB};
    assign dif   = {1'b0, i_wordA} - {1'b0, i_wordB};
    assign msb_a = i_wordA[WIDTH-1];
    assign msb_b = i_wordB[WIDTH-1];

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start, md_done, md_carry, md_divz, is_md;
    logic [WIDTH-1:0] md_result;
    res_t             md_r;

    assign is_md = (i_opcode == OP_MUL) || (i_opcode == OP_DIVU)
                || (i_opcode == OP_REMU);

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (md_start),
        .op      (i_opcode),
        .a       (i_wordA),
        .b       (i_wordB),
        .done    (md_done),
        .result  (md_result),
        .carry   (md_carry),
        .divzero (md_divz)
    );

    always_comb begin
        md_r        = '0;
        md_r.result = md_result;
        md_r.carry  = md_carry;
        md_r.divz   = md_divz;
    end
`endif

    // Single-cycle datapath; zero/sign are filled in from the chosen result
    always_comb begin
        alu_r = '0;
        unique case (i_opcode)
            OP_ADD: begin
                alu_r.result = sum[WIDTH-1:0];
                alu_r.carry  = sum[WIDTH];
                alu_r.ovf    = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
            end
            OP_SUB: begin
                alu_r.result = dif[WIDTH-1:0];
                alu_r.carry  = dif[WIDTH];
                alu_r.ovf    = (msb_a != msb_b) && (dif[WIDTH-1] != msb_a);
            end
            OP_AND:  alu_r.result = i_wordA & i_wordB;
            OP_OR:   alu_r.result = i_wordA | i_wordB;
            OP_XOR:  alu_r.result = i_wordA ^ i_wordB;
            OP_SLL:  alu_r.result = i_wordA << shamt;
            OP_SRL:  alu_r.result = i_wordA >> shamt;
            OP_SRA:  alu_r.result = $unsigned($signed(i_wordA) >>> shamt);
            OP_SLT:  alu_r.result[0] = $signed(i_wordA) < $signed(i_wordB);
            OP_SLTU: alu_r.result[0] = i_wordA < i_wordB;
            OP_SEP:  alu_r.result[0] = ^i_wordA;
            OP_MUL, OP_DIVU, OP_REMU: alu_r = '0;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        res_d   = alu_r;
`ifdef ALU_SEQ_MULDIV_EN
        md_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_md) begin
                        state_d  = S_BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        load    = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    load    = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_BUSY: begin
                res_d = md_r;
                if (md_done) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        res_d.zero = (res_d.result == '0);
        res_d.sign = res_d.result[WIDTH-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) res_q <= res_d;
        end
    end

    assign o_ready         = (state_q == S_IDLE);
    assign o_valid         = (state_q == S_DONE);
    assign o_result        = res_q.result;
    assign o_flag_zero     = res_q.zero;
    assign o_flag_sign     = res_q.sign;
    assign o_flag_overflow = res_q.ovf;
    assign o_flag_carry    = res_q.carry;
    assign o_flag_divzero  = res_q.divz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH = 16 against a behavioural model.
// MUL/DIVU/REMU expectations follow whether ALU_SEQ_MULDIV_EN is defined.
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MD_LAT = W + 1;

    logic         i_clk    = 1'b0;
    logic         i_rst_n  = 1'b0;
    logic         i_valid  = 1'b0;
    logic         i_ready  = 1'b0;
    logic [3:0]   i_opcode = 4'h0;
    logic [W-1:0] i_wordA  = '0;
    logic [W-1:0] i_wordB  = '0;
    logic         o_ready, o_valid;
    logic [W-1:0] o_result;
    logic         o_flag_zero, o_flag_sign, o_flag_overflow;
    logic         o_flag_carry, o_flag_divzero;
    logic [4:0]   obs_f;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [4:0]   f;
        int           lat;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [4:0]   f;
        int           lat;
    } vec_t;

    assign obs_f = {o_flag_zero, o_flag_sign, o_flag_overflow,
                    o_flag_carry, o_flag_divzero};

    alu_seq #(.WIDTH(W)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_opcode        (i_opcode),
        .i_wordA         (i_wordA),
        .i_wordB         (i_wordB),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_result        (o_result),
        .o_flag_zero     (o_flag_zero),
        .o_flag_sign     (o_flag_sign),
        .o_flag_overflow (o_flag_overflow),
        .o_flag_carry    (o_flag_carry),
        .o_flag_divzero  (o_flag_divzero)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // flags packed as {zero, sign, overflow, carry, divzero}
    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, full;
        int     sh;
        logic   c, v, dz;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        full = 0;
        sh = int'(b[3:0]);
        c = 1'b0; v = 1'b0; dz = 1'b0;
        e.r = '0;
        e.lat = 1;
        case (op)
            4'h0: begin
                full = ua + ub;
                e.r = full[W-1:0];
                c = (full > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'h1: begin
                full = ua - ub;
                e.r = full[W-1:0];
                c = (ua < ub);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'h2: e.r = a & b;
            4'h3: e.r = a | b;
            4'h4: e.r = a ^ b;
            4'h5: begin full = ua << sh; e.r = full[W-1:0]; end
            4'h6: begin full = ua >> sh; e.r = full[W-1:0]; end
            4'h7: begin full = sa >>> sh; e.r = full[W-1:0]; end
            4'h8: e.r = {{(W-1){1'b0}}, sa < sb};
            4'h9: e.r = {{(W-1){1'b0}}, ua < ub};
            4'hA: e.r = {{(W-1){1'b0}}, ($countones(a) % 2) == 1};
            4'hB: if (MD) begin
                full = ua * ub;
                e.r = full[W-1:0];
                c = ((full >> W) != 0);
                e.lat = MD_LAT;
            end
            4'hC: if (MD) begin
                e.lat = MD_LAT;
                if (ub == 0) begin e.r = '1; dz = 1'b1; end
                else begin full = ua / ub; e.r = full[W-1:0]; end
            end
            4'hD: if (MD) begin
                e.lat = MD_LAT;
                if (ub == 0) begin e.r = a; dz = 1'b1; end
                else begin full = ua % ub; e.r = full[W-1:0]; end
            end
            default: e.r = '0;
        endcase
        e.f = {e.r == '0, e.r[W-1], v, c, dz};
        return e;
    endfunction

    function automatic logic [W-1:0] pick_word();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Issues one op (called at posedge+1), scrambles inputs while it runs,
    // returns what was observed once o_valid rises, then consumes it.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] r,
                          output logic [4:0] f, output int lat);
        int n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1; n++;
        end
        i_opcode = op; i_wordA = a; i_wordB = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_opcode = 4'($urandom); i_wordA = W'($urandom); i_wordB = W'($urandom);
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk); #1; lat++;
        end
        r = o_result;
        f = obs_f;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        n_cmp++;
        if (o_result !== 16'h0000) begin
            n_err++; $display("FAIL reset_result: got %h want 0000", o_result);
        end
        n_cmp++;
        if (obs_f !== 5'b00000) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", obs_f);
        end
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready %b valid %b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        logic [W-1:0] r;
        logic [4:0] f;
        int lat;
        vecs.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100, 1});
        vecs.push_back('{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 5'b01010, 1});
        vecs.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 1});
        vecs.push_back('{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 1});
        vecs.push_back('{4'h7, 16'h8000, 16'h00FF, 16'hFFFF, 5'b01000, 1});
        vecs.push_back('{4'h5, 16'h0001, 16'h0013, 16'h0008, 5'b00000, 1});
        vecs.push_back('{4'h6, 16'h8000, 16'h000F, 16'h0001, 5'b00000, 1});
        vecs.push_back('{4'hA, 16'h0007, 16'h0000, 16'h0001, 5'b00000, 1});
        vecs.push_back('{4'hA, 16'h0003, 16'h0000, 16'h0000, 5'b10000, 1});
        vecs.push_back('{4'h8, 16'h8000, 16'h0001, 16'h0001, 5'b00000, 1});
        vecs.push_back('{4'h9, 16'h8000, 16'h0001, 16'h0000, 5'b10000, 1});
        vecs.push_back('{4'hE, 16'h1234, 16'h5678, 16'h0000, 5'b10000, 1});
        vecs.push_back('{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10000, 1});
        vecs.push_back('{4'hB, 16'h0100, 16'h0100, 16'h0000,
                         MD ? 5'b10010 : 5'b10000, MD ? MD_LAT : 1});
        vecs.push_back('{4'hC, 16'd100, 16'd0, MD ? 16'hFFFF : 16'h0000,
                         MD ? 5'b01001 : 5'b10000, MD ? MD_LAT : 1});
        vecs.push_back('{4'hD, 16'd100, 16'd7, MD ? 16'h0002 : 16'h0000,
                         MD ? 5'b00000 : 5'b10000, MD ? MD_LAT : 1});
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
            n_cmp++;
            if (r !== vecs[i].r) begin
                n_err++;
                $display("FAIL dir_result op=%h a=%h b=%h: got %h want %h",
                         vecs[i].op, vecs[i].a, vecs[i].b, r, vecs[i].r);
            end
            n_cmp++;
            if (f !== vecs[i].f) begin
                n_err++;
                $display("FAIL dir_flags op=%h a=%h b=%h: got %b want %b",
                         vecs[i].op, vecs[i].a, vecs[i].b, f, vecs[i].f);
            end
            n_cmp++;
            if (lat !== vecs[i].lat) begin
                n_err++;
                $display("FAIL dir_latency op=%h: got %0d want %0d",
                         vecs[i].op, lat, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] a, b, r;
        logic [4:0] f;
        int lat;
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick_word();
            b = pick_word();
            e = model(op, a, b);
            run_op(op, a, b, r, f, lat);
            n_cmp++;
            if (r !== e.r || f !== e.f) begin
                n_err++;
                $display("FAIL rnd_value op=%h a=%h b=%h: got %h/%b want %h/%b",
                         op, a, b, r, f, e.r, e.f);
            end
            n_cmp++;
            if (lat !== e.lat) begin
                n_err++;
                $display("FAIL rnd_latency op=%h: got %0d want %0d", op, lat, e.lat);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] op;
        logic [W-1:0] a, b;
        exp_t e;
        int lat = 1;
        op = 4'($urandom_range(0, 13));
        a = pick_word();
        b = pick_word();
        e = model(op, a, b);
        i_opcode = op; i_wordA = a; i_wordB = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk); #1; lat++;
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++; $display("FAIL hold_latency: got %0d want %0d", lat, e.lat);
        end
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_opcode = 4'($urandom); i_wordA = W'($urandom); i_wordB = W'($urandom);
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_result !== e.r || obs_f !== e.f) begin
                n_err++;
                $display("FAIL hold_stable cycle %0d: got %h/%b want %h/%b",
                         i, o_result, obs_f, e.r, e.f);
            end
            n_cmp++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
                n_err++;
                $display("FAIL hold_handshake cycle %0d: ready %b valid %b want 0 1",
                         i, o_ready, o_valid);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_ignored cycle %0d: ready %b valid %b want 1 0",
                         i, o_ready, o_valid);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int acc = 0;
        int cyc = 0;
        bit will_acc;
        i_ready = 1'b1;
        i_opcode = 4'($urandom); i_wordA = pick_word(); i_wordB = pick_word();
        i_valid = 1'b1;
        while ((acc < 40 || q.size() != 0) && cyc < 3000) begin
            if (o_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected: result %h with nothing pending", o_result);
                end else begin
                    e = q.pop_front();
                    if (o_result !== e.r || obs_f !== e.f) begin
                        n_err++;
                        $display("FAIL b2b_value: got %h/%b want %h/%b",
                                 o_result, obs_f, e.r, e.f);
                    end
                end
            end
            will_acc = i_valid && o_ready;
            if (will_acc) begin
                q.push_back(model(i_opcode, i_wordA, i_wordB));
                acc++;
            end
            @(posedge i_clk); #1;
            cyc++;
            i_opcode = 4'($urandom); i_wordA = pick_word(); i_wordB = pick_word();
            i_valid = (acc < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
        n_cmp++;
        if (acc != 40 || q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: accepted %0d pending %0d want 40 0", acc, q.size());
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] op;
        logic [W-1:0] r;
        logic [4:0] f;
        int lat;
        bit seen = 1'b0;
        exp_t e;
        op = MD ? 4'hB : 4'h0;
        run_op(4'h0, 16'd3, 16'd4, r, f, lat);
        n_cmp++;
        if (r !== 16'd7) begin
            n_err++; $display("FAIL rst_pre_result: got %h want 0007", r);
        end
        i_opcode = op; i_wordA = 16'd3; i_wordB = 16'd5; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (MD ? 5 : 0) begin
            @(posedge i_clk); #1;
        end
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_in_flight: ready %b want 0", o_ready);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_async_valid: got %b want 0", o_valid);
        end
        n_cmp++;
        if (o_result !== 16'h0000 || obs_f !== 5'b00000) begin
            n_err++;
            $display("FAIL rst_async_result: got %h/%b want 0000/00000", o_result, obs_f);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_ready: got %b want 1", o_ready);
        end
        repeat (W + 4) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL rst_abandon: o_valid %b after reset want 0", seen);
        end
        e = model(op, 16'd3, 16'd5);
        run_op(op, 16'd3, 16'd5, r, f, lat);
        n_cmp++;
        if (r !== e.r || f !== e.f || lat !== e.lat) begin
            n_err++;
            $display("FAIL rst_next_op: got %h/%b lat %0d want %h/%b lat %0d",
                     r, f, lat, e.r, e.f, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
